// File: rtl/branch_redirect_ctrl_if.sv
// Branch/redirect bundle between decode, execute, fetch and the redirect controller.
// master = the environment side driving branches, flags and acks; slave = the controller.
interface branch_redirect_ctrl_if;
    logic        br_valid;
    logic        br_ready;
    logic [63:0] br_pc;
    logic [63:0] br_imm;
    logic [1:0]  br_kind;
    logic        ex_flags_valid;
    logic        ex_zero;
    logic        ex_neg;
    logic        ex_ovf;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        redirect_ack;
    logic        flush;
    logic        link_we;
    logic [63:0] link_data;

    modport master (
        output br_valid, br_pc, br_imm, br_kind,
        output ex_flags_valid, ex_zero, ex_neg, ex_ovf,
        output redirect_ack,
        input  br_ready, redirect_valid, redirect_pc, flush, link_we, link_data
    );

    modport slave (
        input  br_valid, br_pc, br_imm, br_kind,
        input  ex_flags_valid, ex_zero, ex_neg, ex_ovf,
        input  redirect_ack,
        output br_ready, redirect_valid, redirect_pc, flush, link_we, link_data
    );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: one outstanding branch, resolves it, redirects fetch, then flushes.
// Define BRANCH_LINK_EN to enable the X30 link writeback for BL (kind 01).
//
// state      | meaning
// IDLE       | ready to accept a branch
// WAIT_FLAGS | conditional branch waiting for resolved flags from execute
// REDIRECT   | offering redirect_pc to fetch until acked
// FLUSH      | squashing younger IF/ID instructions for FLUSH_CYCLES cycles
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input logic                   clk,
    input logic                   reset,
    branch_redirect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, WAIT_FLAGS, REDIRECT, FLUSH} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] target_q;
    logic        cond_lt_q;
    logic [2:0]  flush_cnt;
    logic        accept;
    logic        taken;

    assign accept = bus.br_valid && (state == IDLE);
    // cond_lt_q selects B.LT (neg ^ ovf) over CBZ (zero) for the stored conditional
    assign taken  = cond_lt_q ? (bus.ex_neg ^ bus.ex_ovf) : bus.ex_zero;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt          = state;
        bus.br_ready       = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.flush          = 1'b0;
        case (state)
            IDLE: begin
                bus.br_ready = 1'b1;
                if (accept) state_nxt = bus.br_kind[1] ? WAIT_FLAGS : REDIRECT;
            end
            WAIT_FLAGS: begin
                if (bus.ex_flags_valid) state_nxt = taken ? REDIRECT : IDLE;
            end
            REDIRECT: begin
                bus.redirect_valid = 1'b1;
                if (bus.redirect_ack) state_nxt = FLUSH;
            end
            FLUSH: begin
                bus.flush = 1'b1;
                if (flush_cnt == 3'd0) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // flush_cnt counts down the remaining flush cycles; terminal count 0 ends FLUSH
    always_ff @(posedge clk) begin
        if (reset) begin
            target_q  <= '0;
            cond_lt_q <= 1'b0;
            flush_cnt <= '0;
        end else begin
            if (accept) begin
                target_q  <= bus.br_pc + bus.br_imm;
                cond_lt_q <= bus.br_kind[0];
            end
            if (state == REDIRECT && bus.redirect_ack)
                flush_cnt <= 3'(FLUSH_CYCLES - 1);
            else if (state == FLUSH && flush_cnt != 3'd0)
                flush_cnt <= flush_cnt - 3'd1;
        end
    end

    assign bus.redirect_pc = target_q;

`ifdef BRANCH_LINK_EN
    logic        link_we_q;
    logic [63:0] link_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            link_we_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            link_we_q <= accept && (bus.br_kind == 2'b01);
            if (accept && (bus.br_kind == 2'b01))
                link_data_q <= bus.br_pc + 64'd4;
        end
    end

    assign bus.link_we   = link_we_q;
    assign bus.link_data = link_data_q;
`else
    assign bus.link_we   = 1'b0;
    assign bus.link_data = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Randomized scoreboard bench for branch_redirect_ctrl; honours BRANCH_LINK_EN when defined.
module tb_branch_redirect_ctrl;

    localparam int FC = 2;
`ifdef BRANCH_LINK_EN
    localparam bit LINK_EN = 1'b1;
`else
    localparam bit LINK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   flush_run = 0;

    logic [63:0] exp_redirect_q[$];
    logic [63:0] exp_link_q[$];

    branch_redirect_ctrl_if bus();

    branch_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event seen with nothing expected at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_br_ready", bus.br_ready, 1);
        check("rst_redirect_valid", bus.redirect_valid, 0);
        check("rst_redirect_pc", bus.redirect_pc, 0);
        check("rst_flush", bus.flush, 0);
        check("rst_link_we", bus.link_we, 0);
        check("rst_link_data", bus.link_data, 0);
    endtask

    // Monitor: pops expected redirects/link writes as the DUT presents them.
    always @(negedge clk) begin
        if (reset) begin
            flush_run = 0;
        end else begin
            if (bus.redirect_valid && bus.redirect_ack) begin
                if (exp_redirect_q.size() == 0) fail_now("redirect_unexpected");
                else check("redirect_pc", bus.redirect_pc, exp_redirect_q.pop_front());
            end
            if (bus.flush) flush_run++;
            else if (flush_run > 0) begin
                check("flush_len", flush_run, FC);
                flush_run = 0;
            end
`ifdef BRANCH_LINK_EN
            if (bus.link_we) begin
                if (exp_link_q.size() == 0) fail_now("link_unexpected");
                else check("link_data", bus.link_data, exp_link_q.pop_front());
            end
`else
            check("link_tied", bus.link_data | 64'(bus.link_we), 0);
`endif
        end
    end

    // reset_at: 0 none, 1 reset while in REDIRECT, 2 reset in first FLUSH cycle
    task automatic do_branch(input logic [63:0] pc, input logic [63:0] imm, input logic [1:0] kind,
                             input int flag_delay, input logic z, input logic n, input logic v,
                             input int ack_delay, input int reset_at);
        logic        taken;
        logic [63:0] tgt;
        int          cnt;
        tgt = pc + imm;
        case (kind)
            2'b10:   taken = z;
            2'b11:   taken = n ^ v;
            default: taken = 1'b1;
        endcase
        bus.ex_flags_valid = 1'b0;
        bus.redirect_ack   = 1'b0;
        cnt = 0;
        while (!bus.br_ready && cnt < 50) begin step(); cnt++; end
        check("ready_wait", bus.br_ready, 1);

        bus.br_valid = 1'b1;
        bus.br_pc    = pc;
        bus.br_imm   = imm;
        bus.br_kind  = kind;
        if (taken) exp_redirect_q.push_back(tgt);
        if (LINK_EN && kind == 2'b01) exp_link_q.push_back(pc + 64'd4);
        step();
        bus.br_valid = 1'b0;
        bus.br_pc    = {$urandom, $urandom};
        bus.br_imm   = {$urandom, $urandom};
        check("link_we_pulse", bus.link_we, LINK_EN && kind == 2'b01);
        check("busy_not_ready", bus.br_ready, 0);

        if (kind[1]) begin
            for (int i = 0; i < flag_delay; i++) begin
                check("wait_no_redirect", bus.redirect_valid, 0);
                bus.ex_zero      = 1'($urandom);
                bus.ex_neg       = 1'($urandom);
                bus.ex_ovf       = 1'($urandom);
                bus.redirect_ack = 1'($urandom);
                step();
                check("wait_not_ready", bus.br_ready, 0);
            end
            bus.ex_flags_valid = 1'b1;
            bus.ex_zero        = z;
            bus.ex_neg         = n;
            bus.ex_ovf         = v;
            bus.redirect_ack   = 1'($urandom);
            step();
            bus.ex_flags_valid = 1'b0;
            bus.redirect_ack   = 1'b0;
        end
        check("redirect_latency", bus.redirect_valid, taken);

        if (!taken) begin
            check("nt_flush", bus.flush, 0);
            check("nt_ready", bus.br_ready, 1);
            return;
        end

        if (reset_at == 1) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            exp_redirect_q.delete();
            check_reset_values();
            return;
        end

        for (int i = 0; i < ack_delay; i++) begin
            bus.br_valid = 1'($urandom);
            bus.br_kind  = 2'($urandom);
            step();
            check("stall_valid", bus.redirect_valid, 1);
            check("stall_pc", bus.redirect_pc, tgt);
            check("stall_not_ready", bus.br_ready, 0);
        end
        bus.br_valid     = 1'b0;
        bus.redirect_ack = 1'b1;
        step();
        bus.redirect_ack = 1'b0;

        if (reset_at == 2) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            check_reset_values();
            return;
        end

        cnt = 0;
        while (!bus.br_ready && cnt < 20) begin step(); cnt++; end
        check("flush_to_ready", cnt, FC);
    endtask

    initial begin
        bus.br_valid       = 1'b0;
        bus.br_pc          = '0;
        bus.br_imm         = '0;
        bus.br_kind        = '0;
        bus.ex_flags_valid = 1'b0;
        bus.ex_zero        = 1'b0;
        bus.ex_neg         = 1'b0;
        bus.ex_ovf         = 1'b0;
        bus.redirect_ack   = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check_reset_values();

        do_branch(64'h1000, 64'h40, 2'b00, 0, 0, 0, 0, 0, 0);
        do_branch(64'h2000, -64'sd8, 2'b10, 3, 1, 0, 0, 0, 0);
        do_branch(64'h2000, -64'sd8, 2'b10, 3, 0, 0, 0, 0, 0);
        do_branch(64'h2400, 64'h100, 2'b11, 1, 0, 1, 0, 1, 0);
        do_branch(64'h2400, 64'h100, 2'b11, 1, 0, 1, 1, 1, 0);
        do_branch(64'h3000, 64'h80, 2'b01, 0, 0, 0, 0, 0, 0);
        do_branch(64'h5000, 64'h10, 2'b00, 0, 0, 0, 0, 5, 0);
        do_branch(64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 2'b00, 0, 0, 0, 0, 1, 0);
        do_branch(64'h6000, 64'h44, 2'b01, 0, 0, 0, 0, 0, 2);
        do_branch(64'h7000, 64'h8, 2'b11, 2, 0, 0, 1, 2, 1);

        for (int k = 0; k < 60; k++) begin
            bus.ex_flags_valid = 1'($urandom);
            bus.ex_zero        = 1'($urandom);
            bus.redirect_ack   = 1'($urandom);
            step();
            check("gap_ready", bus.br_ready, 1);
            check("gap_no_redirect", bus.redirect_valid | bus.flush, 0);
            do_branch({$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                                      : 64'(signed'(32'($urandom)) <<< 2),
                      2'($urandom), $urandom_range(0, 4), 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), 0);
        end

        repeat (4) step();
        check("redirect_leftover", exp_redirect_q.size(), 0);
        check("link_leftover", exp_link_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d failures %0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, meaning cycles flush is held high after each accepted redirect (legal 1..7).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port br_valid, input, 1, decode presents a branch.
REQ-005 The block SHALL have port br_ready, output, 1, block can accept a branch this cycle.
REQ-006 The block SHALL have port br_pc, input, 64, PC of the branch instruction.
REQ-007 The block SHALL have port br_imm, input, 64, sign-extended byte offset, already shifted left by 2.
REQ-008 The block SHALL have port br_kind, input, 2, branch kind: 00 B, 01 BL, 10 CBZ (taken if zero), 11 B.LT (taken if neg XOR ovf).
REQ-009 The block SHALL have ports ex_flags_valid, ex_zero, ex_neg, ex_ovf, input, 1 each, resolved condition from execute.
REQ-010 The block SHALL have port redirect_valid, output, 1, new fetch PC offered.
REQ-011 The block SHALL have port redirect_pc, output, 64, target PC.
REQ-012 The block SHALL have port redirect_ack, input, 1, fetch accepts redirect.
REQ-013 The block SHALL have port flush, output, 1, squash younger IF/ID instructions.
REQ-014 The block SHALL have ports link_we, output, 1, and link_data, output, 64, write of X30.

Function
REQ-015 States SHALL be IDLE, WAIT_FLAGS, REDIRECT, FLUSH; br_ready SHALL be 1 only in IDLE.
REQ-016 Acceptance SHALL occur on a cycle with br_valid && br_ready; br_pc, br_imm, br_kind are captured that edge.
REQ-017 Target SHALL be br_pc + br_imm modulo 2^64 (wrap-around, no overflow flag); fall-through SHALL be br_pc + 4.
REQ-018 On accepting kind 00/01, next state SHALL be REDIRECT with redirect_pc = target.
REQ-019 On accepting kind 10/11, next state SHALL be WAIT_FLAGS.
REQ-020 In WAIT_FLAGS, flags SHALL be sampled only when ex_flags_valid=1; taken -> REDIRECT with target; not taken -> IDLE, no redirect, no flush.
REQ-021 In REDIRECT, redirect_valid SHALL be 1 and redirect_pc stable until redirect_ack; on ack, next state SHALL be FLUSH.
REQ-022 In FLUSH, flush SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles, then state SHALL return to IDLE.
REQ-023 Latency: unconditional branch accepted at cycle N SHALL assert redirect_valid at N+1; taken conditional resolved at cycle M SHALL assert redirect_valid at M+1.
REQ-024 redirect_ack while redirect_valid=0 SHALL be ignored; ex_flags_valid outside WAIT_FLAGS SHALL be ignored.
REQ-025 A new branch SHALL NOT be accepted before the state returns to IDLE (one outstanding branch max).

Reset
REQ-026 reset SHALL take effect at the next clk edge from any state, including mid-REDIRECT or mid-FLUSH, and abandon the outstanding branch.
REQ-027 Reset values: state IDLE, br_ready 1 after reset deasserts, redirect_valid 0, redirect_pc 0, flush 0, link_we 0, link_data 0, flush counter 0.

Configuration
REQ-028 Macro BRANCH_LINK_EN SHALL control link writeback.
REQ-029 With BRANCH_LINK_EN defined, acceptance of kind 01 SHALL pulse link_we for one cycle (cycle after acceptance) with link_data = br_pc + 4.
REQ-030 Without BRANCH_LINK_EN, link_we and link_data SHALL be tied 0 and kind 01 SHALL behave as kind 00.

Verification
REQ-031 B at br_pc=0x1000, br_imm=0x40, redirect_ack immediate -> redirect_pc=0x1040 one cycle later, then flush high exactly 2 cycles, br_ready back.
REQ-032 CBZ at 0x2000, br_imm=-8, ex_flags_valid=1 with ex_zero=1 three cycles later -> redirect_pc=0x1FF8; repeat with ex_zero=0 -> no redirect_valid, no flush, IDLE.
REQ-033 B.LT, ex_neg=1, ex_ovf=0 -> taken; ex_neg=1, ex_ovf=1 -> not taken.
REQ-034 BL at 0x3000 with BRANCH_LINK_EN -> link_we one cycle, link_data=0x3004; without macro -> link_we stays 0.
REQ-035 redirect_ack held low 5 cycles -> redirect_valid and redirect_pc stable, br_valid ignored; reset asserted in FLUSH -> all outputs at reset values next edge.
REQ-036 br_pc=0xFFFFFFFFFFFFFFF0, br_imm=0x20 -> redirect_pc=0x10 (wrap).
